regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of write requesters, 2..8.
REQ-002 Parameter RF_BASE, default 5: lowest architectural register index held by the register file.
REQ-003 Parameter RF_COUNT, default 3: number of physical registers; the valid window is RF_BASE..RF_BASE+RF_COUNT-1.
REQ-004 clk  input  1: single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1: reset, synchronous and active-low.
REQ-006 freeze  input  1: pipeline stall; when high, no request is accepted.
REQ-007 req_valid  input  NREQ: per-requester write request.
REQ-008 req_rd  input  NREQ*5: per-requester destination index; slice i is bits [5i+4:5i].
REQ-009 req_value  input  NREQ*32: per-requester write data; slice i is bits [32i+31:32i].
REQ-010 req_ready  output  NREQ: one-hot-or-zero grant; combinational from req_valid, freeze, rst_n and the priority pointer.
REQ-011 wr_we  output  1: registered write enable to the register file.
REQ-012 wr_rd  output  5: registered destination index, unmodified architectural index.
REQ-013 wr_value  output  32: registered write data.
REQ-014 drop_count  output  8: saturating count of accepted out-of-window writes.
REQ-015 last_grant  output  3: index of the most recently accepted requester.

Function
REQ-016 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both high at posedge clk.
REQ-017 At most one req_ready bit SHALL be high per cycle; all bits SHALL be low when freeze=1 or rst_n=0.
REQ-018 Arbitration SHALL be round-robin: search starts at pointer ptr and wraps, ptr+1, ..., NREQ-1, 0, ..., ptr-1; the first valid requester is granted.
REQ-019 After a transfer from requester i, ptr SHALL become (i+1) mod NREQ; with no transfer, ptr SHALL hold.
REQ-020 The winning request SHALL be registered: wr_we, wr_rd and wr_value reflect it exactly one cycle after the transfer (latency 1).
REQ-021 wr_we SHALL be high only in the cycle after an in-window transfer and low in every other cycle; there are no multi-cycle holds.
REQ-022 When wr_we is low, wr_rd and wr_value SHALL hold their previous values.
REQ-023 An out-of-window transfer (rd < RF_BASE or rd >= RF_BASE+RF_COUNT) SHALL be accepted and SHALL leave wr_we low in the next cycle.
REQ-024 Each out-of-window transfer SHALL increment drop_count by 1, and drop_count SHALL saturate at 255.
REQ-025 Window comparison SHALL be unsigned on 5 bits; rd=0 and rd=31 are out-of-window for the default parameters.
REQ-026 Asserting freeze SHALL not alter ptr or drop_count, and SHALL force wr_we low in the following cycle.
REQ-027 A requester not granted SHALL keep its request pending without loss; the arbiter stores no request internally.
REQ-028 last_grant SHALL update on every transfer and hold otherwise.

Reset
REQ-029 While rst_n=0 at posedge clk: ptr=0, wr_we=0, wr_rd=0, wr_value=0, drop_count=0, last_grant=0.
REQ-030 A transfer presented in the same cycle as rst_n=0 SHALL be discarded; the first grant after reset release SHALL go to the lowest valid index.

Structure
REQ-031 Constants RF_BASE_DEFAULT=5, RF_COUNT_DEFAULT=3, REG_IDX_W=5, DATA_W=32 and DROP_CNT_W=8 SHALL reside in shared package regfile_pkg.
REQ-032 Round-robin selection (ptr, valid vector -> one-hot grant, encoded index) SHALL be a sub-module rr_arbiter, parameterised by NREQ and purely combinational.

Verification
REQ-033 Reset, then req_valid=3'b111 held for 6 cycles, all rd=5 -> grants follow the order 0,1,2,0,1,2 and wr_we is high for 6 consecutive cycles, starting one cycle late.
REQ-034 req 1 only: rd=6, value=32'hDEADBEEF -> next cycle wr_we=1, wr_rd=6, wr_value=DEADBEEF; the cycle after that, wr_we=0.
REQ-035 300 transfers with rd=2 -> wr_we never high; drop_count=255 at the end.
REQ-036 freeze=1 with req_valid=3'b101 for 4 cycles -> req_ready=0 and ptr unchanged; after freeze drops, the grant goes to index 0 from reset state.
REQ-037 rst_n=0 asserted for one cycle mid-stream after grants 0,1 -> outputs zero next cycle; the next grant goes to 0, not 2.
REQ-038 Requester 2 rd=7 held while 0 and 1 request continuously -> requester 2 is granted within 3 cycles and its value appears unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write arbiter.
package regfile_pkg;

   localparam int RF_BASE_DEFAULT  = 5;
   localparam int RF_COUNT_DEFAULT = 3;
   localparam int REG_IDX_W        = 5;
   localparam int DATA_W           = 32;
   localparam int DROP_CNT_W       = 8;
   localparam int GRANT_W          = 3;

   localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

   // One write toward the register file: architectural index plus data.
   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic [DATA_W-1:0]    value;
   } wr_req_t;

   // Unsigned window test: base <= rd < base+count, rd zero-extended.
   function automatic logic in_window(input logic [REG_IDX_W-1:0] rd,
                                      input int base, input int count);
      int r;
      r = 0;
      r[REG_IDX_W-1:0] = rd;
      return (r >= base) && (r < base + count);
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Combinational round-robin picker: search starts at ptr and wraps.
module rr_arbiter #(
   parameter int NREQ = 3
) (
   input  logic [$clog2(NREQ)-1:0] ptr,
   input  logic [NREQ-1:0]         valid,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] idx,
   output logic                    any
);

   localparam int IDX_W = $clog2(NREQ);

   int               j;
   logic [IDX_W-1:0] jj;

   // Walk candidates ptr, ptr+1, ... (mod NREQ); first valid one wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      jj    = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         jj = IDX_W'(j);
         if (!any && valid[jj]) begin
            grant[jj] = 1'b1;
            idx       = jj;
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter in front of a windowed register file.
// Out-of-window writes are accepted but dropped and counted.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int NREQ     = 3,
   parameter int RF_BASE  = RF_BASE_DEFAULT,
   parameter int RF_COUNT = RF_COUNT_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       freeze,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ*REG_IDX_W-1:0]  req_rd,
   input  logic [NREQ*DATA_W-1:0]     req_value,
   output logic [NREQ-1:0]            req_ready,
   output logic                       wr_we,
   output logic [REG_IDX_W-1:0]       wr_rd,
   output logic [DATA_W-1:0]          wr_value,
   output logic [DROP_CNT_W-1:0]      drop_count,
   output logic [GRANT_W-1:0]         last_grant
);

   localparam int IDX_W = $clog2(NREQ);

   logic [NREQ-1:0][REG_IDX_W-1:0] rd_arr;
   logic [NREQ-1:0][DATA_W-1:0]    val_arr;
   logic [IDX_W-1:0]               ptr;
   logic [IDX_W-1:0]               gnt_idx;
   logic [IDX_W-1:0]               next_ptr;
   logic [NREQ-1:0]                gnt;
   logic                           gnt_any;
   logic                           accept_en;
   logic                           xfer;
   logic                           in_win;
   wr_req_t                        win_req;
   wr_req_t                        wr_q;
   logic                           we_q;
   logic [DROP_CNT_W-1:0]          drop_q;
   logic [GRANT_W-1:0]             last_q;

   assign rd_arr  = req_rd;
   assign val_arr = req_value;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .ptr   (ptr),
      .valid (req_valid),
      .grant (gnt),
      .idx   (gnt_idx),
      .any   (gnt_any)
   );

   // Grants are masked during reset and stall so nothing transfers then.
   assign accept_en = rst_n & ~freeze;
   assign req_ready = accept_en ? gnt : '0;
   assign xfer      = accept_en & gnt_any;

   assign win_req.rd    = rd_arr[gnt_idx];
   assign win_req.value = val_arr[gnt_idx];
   assign in_win        = in_window(win_req.rd, RF_BASE, RF_COUNT);

   assign next_ptr = (gnt_idx == IDX_W'(NREQ-1)) ? '0 : gnt_idx + IDX_W'(1);

   // Write-port register: pulse we for one cycle, data holds when idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_q <= 1'b0;
         wr_q <= '0;
      end else begin
         we_q <= xfer & in_win;
         if (xfer && in_win) wr_q <= win_req;
      end
   end

   // Priority pointer and last winner advance only on a transfer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr    <= '0;
         last_q <= '0;
      end else if (xfer) begin
         ptr    <= next_ptr;
         last_q <= GRANT_W'(gnt_idx);
      end
   end

   // Saturating count of accepted writes that fall outside the window.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_q <= '0;
      end else if (xfer && !in_win && drop_q != DROP_MAX) begin
         drop_q <= drop_q + DROP_CNT_W'(1);
      end
   end

   assign wr_we      = we_q;
   assign wr_rd      = wr_q.rd;
   assign wr_value   = wr_q.value;
   assign drop_count = drop_q;
   assign last_grant = last_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table plus corner sequences,
// registered outputs checked through an expected-result queue.
module tb_regfile_write_arbiter;
   import regfile_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         freeze;
   logic [2:0]   req_valid;
   logic [14:0]  req_rd;
   logic [95:0]  req_value;
   logic [2:0]   req_ready;
   logic         wr_we;
   logic [4:0]   wr_rd;
   logic [31:0]  wr_value;
   logic [7:0]   drop_count;
   logic [2:0]   last_grant;

   always #5 clk = ~clk;

   regfile_write_arbiter #(.NREQ(3), .RF_BASE(5), .RF_COUNT(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .freeze     (freeze),
      .req_valid  (req_valid),
      .req_rd     (req_rd),
      .req_value  (req_value),
      .req_ready  (req_ready),
      .wr_we      (wr_we),
      .wr_rd      (wr_rd),
      .wr_value   (wr_value),
      .drop_count (drop_count),
      .last_grant (last_grant)
   );

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] val;
      logic [7:0]  drop;
      logic [2:0]  last;
   } exp_t;

   typedef struct {
      logic        rst;
      logic        frz;
      logic [2:0]  v;
      logic [4:0]  r0, r1, r2;
      logic [31:0] d0, d1, d2;
      logic [2:0]  exp_rdy;
   } vec_t;

   exp_t sbq[$];
   vec_t tbl[$];

   int total = 0;
   int bad   = 0;

   int          m_ptr  = 0;
   logic [7:0]  m_drop = '0;
   logic [2:0]  m_last = '0;
   logic [4:0]  m_rd   = '0;
   logic [31:0] m_val  = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic int model_pick(input logic [2:0] v, input int p);
      for (int k = 0; k < 3; k++) begin
         int c;
         c = (p + k) % 3;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   // One clock: drive, check grant, predict registered outputs, compare.
   task automatic step(input logic rst, input logic frz, input logic [2:0] v,
                       input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       output logic [2:0] rdy_seen);
      int          g;
      logic [2:0]  exp_rdy;
      logic [4:0]  rsel;
      logic [31:0] dsel;
      exp_t        e;
      exp_t        got;
      @(negedge clk);
      rst_n     = rst;
      freeze    = frz;
      req_valid = v;
      req_rd    = {r2, r1, r0};
      req_value = {d2, d1, d0};
      #1;
      rdy_seen = req_ready;
      g        = (rst && !frz) ? model_pick(v, m_ptr) : -1;
      exp_rdy  = (g >= 0) ? 3'(1 << g) : 3'b000;
      chk("req_ready", {29'd0, req_ready}, {29'd0, exp_rdy});
      e.we = 1'b0;
      if (!rst) begin
         m_ptr = 0; m_drop = '0; m_last = '0; m_rd = '0; m_val = '0;
      end else if (g >= 0) begin
         rsel   = (g == 0) ? r0 : (g == 1) ? r1 : r2;
         dsel   = (g == 0) ? d0 : (g == 1) ? d1 : d2;
         m_ptr  = (g + 1) % 3;
         m_last = 3'(g);
         if (rsel >= 5 && rsel <= 7) begin
            e.we  = 1'b1;
            m_rd  = rsel;
            m_val = dsel;
         end else if (m_drop != 8'd255) begin
            m_drop = m_drop + 8'd1;
         end
      end
      e.rd = m_rd; e.val = m_val; e.drop = m_drop; e.last = m_last;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         total++; bad++;
         $display("FAIL scoreboard: got empty queue want entry");
      end else begin
         got = sbq.pop_front();
         chk("wr_we",      {31'd0, wr_we},      {31'd0, got.we});
         chk("wr_rd",      {27'd0, wr_rd},      {27'd0, got.rd});
         chk("wr_value",   wr_value,            got.val);
         chk("drop_count", {24'd0, drop_count}, {24'd0, got.drop});
         chk("last_grant", {29'd0, last_grant}, {29'd0, got.last});
      end
   endtask

   function automatic vec_t mkv(input logic rst, input logic frz, input logic [2:0] v,
                                input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [2:0] exp_rdy);
      vec_t t;
      t.rst = rst; t.frz = frz; t.v = v;
      t.r0 = r0; t.r1 = r1; t.r2 = r2;
      t.d0 = d0; t.d1 = d1; t.d2 = d2;
      t.exp_rdy = exp_rdy;
      return t;
   endfunction

   initial begin
      logic [2:0] rdy;
      logic       hit;
      rst_n = 1'b0; freeze = 1'b0; req_valid = '0; req_rd = '0; req_value = '0;

      // reset with requests present, then 0,1,2,0,1,2, then window edges
      tbl.push_back(mkv(0, 0, 3'b111, 5, 5, 5, 32'h11, 32'h12, 32'h13, 3'b000));
      tbl.push_back(mkv(0, 0, 3'b111, 5, 5, 5, 32'h11, 32'h12, 32'h13, 3'b000));
      tbl.push_back(mkv(1, 0, 3'b111, 5, 5, 5, 32'h100, 32'h101, 32'h102, 3'b001));
      tbl.push_back(mkv(1, 0, 3'b111, 5, 5, 5, 32'h110, 32'h111, 32'h112, 3'b010));
      tbl.push_back(mkv(1, 0, 3'b111, 5, 5, 5, 32'h120, 32'h121, 32'h122, 3'b100));
      tbl.push_back(mkv(1, 0, 3'b111, 5, 5, 5, 32'h130, 32'h131, 32'h132, 3'b001));
      tbl.push_back(mkv(1, 0, 3'b111, 5, 5, 5, 32'h140, 32'h141, 32'h142, 3'b010));
      tbl.push_back(mkv(1, 0, 3'b111, 5, 5, 5, 32'h150, 32'h151, 32'h152, 3'b100));
      tbl.push_back(mkv(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000));
      tbl.push_back(mkv(1, 0, 3'b010, 0, 6, 0, 0, 32'hDEADBEEF, 0, 3'b010));
      tbl.push_back(mkv(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000));
      tbl.push_back(mkv(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000));
      tbl.push_back(mkv(1, 0, 3'b001, 31, 0, 0, 32'hA1, 0, 0, 3'b001));
      tbl.push_back(mkv(1, 0, 3'b001, 0, 0, 0, 32'hA2, 0, 0, 3'b001));
      tbl.push_back(mkv(1, 0, 3'b100, 0, 0, 7, 0, 0, 32'hA3, 3'b100));
      tbl.push_back(mkv(1, 0, 3'b010, 0, 8, 0, 0, 32'hA4, 0, 3'b010));
      tbl.push_back(mkv(1, 0, 3'b001, 4, 0, 0, 32'hA5, 0, 0, 3'b001));
      tbl.push_back(mkv(1, 1, 3'b111, 7, 5, 6, 1, 2, 3, 3'b000));
      tbl.push_back(mkv(1, 0, 3'b111, 7, 5, 6, 1, 2, 3, 3'b010));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].frz, tbl[i].v, tbl[i].r0, tbl[i].r1, tbl[i].r2,
              tbl[i].d0, tbl[i].d1, tbl[i].d2, rdy);
         chk($sformatf("tbl%0d_ready", i), {29'd0, rdy}, {29'd0, tbl[i].exp_rdy});
         if (i == 9) begin
            chk("beef_we", {31'd0, wr_we}, 32'd1);
            chk("beef_rd", {27'd0, wr_rd}, 32'd6);
            chk("beef_value", wr_value, 32'hDEADBEEF);
         end
         if (i == 10) chk("beef_we_drop", {31'd0, wr_we}, 32'd0);
      end
      chk("tbl_drops", {24'd0, drop_count}, 32'd4);

      // stall from reset state: no grant, then index 0 wins
      step(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, rdy);
      for (int i = 0; i < 4; i++) step(1, 1, 3'b101, 5, 5, 5, 7, 8, 9, rdy);
      chk("frz_drop", {24'd0, drop_count}, 32'd0);
      step(1, 0, 3'b101, 5, 5, 5, 7, 8, 9, rdy);
      chk("frz_release_ready", {29'd0, rdy}, 32'd1);

      // reset mid-stream after grants 0,1: next grant returns to 0
      step(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, rdy);
      step(1, 0, 3'b111, 5, 6, 7, 32'h21, 32'h22, 32'h23, rdy);
      step(1, 0, 3'b111, 5, 6, 7, 32'h21, 32'h22, 32'h23, rdy);
      step(0, 0, 3'b111, 5, 6, 7, 32'h21, 32'h22, 32'h23, rdy);
      chk("mid_rst_we", {31'd0, wr_we}, 32'd0);
      chk("mid_rst_value", wr_value, 32'd0);
      chk("mid_rst_last", {29'd0, last_grant}, 32'd0);
      step(1, 0, 3'b111, 5, 6, 7, 32'h21, 32'h22, 32'h23, rdy);
      chk("mid_rst_next_ready", {29'd0, rdy}, 32'd1);

      // requester 2 starved by 0 and 1 must still win within 3 cycles
      step(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, rdy);
      hit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (!hit) begin
            step(1, 0, 3'b111, 5, 6, 7, 32'h31, 32'h32, 32'hCAFEF00D, rdy);
            if (rdy[2]) begin
               hit = 1'b1;
               chk("starve_rd", {27'd0, wr_rd}, 32'd7);
               chk("starve_value", wr_value, 32'hCAFEF00D);
            end
         end
      end
      chk("starve_granted", {31'd0, hit}, 32'd1);

      // 300 out-of-window transfers saturate the drop counter
      step(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, rdy);
      for (int i = 0; i < 300; i++) step(1, 0, 3'b111, 2, 2, 2, i, i + 1, i + 2, rdy);
      chk("drop_saturated", {24'd0, drop_count}, 32'd255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
